// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between the fetch/data requesters, the arbiter and the shared memory
//
// Purpose: groups every handshake and bus signal of mem_arbiter into one bundle.
// Ports (signals):
//   fetch   : i_req, i_addr[31:0]                 -> arbiter ; i_ready, i_rdata[31:0] <- arbiter
//   data    : d_req, d_we, d_addr, d_wdata[31:0]  -> arbiter ; d_ready, d_rdata[31:0] <- arbiter
//   memory  : mem_req, mem_we, mem_addr, mem_wdata <- arbiter ; mem_ready, mem_rdata    -> arbiter
//   status  : bus_err (timeout abort pulse), busy (transaction in flight) <- arbiter
// Modports: slave = arbiter view, master = environment view (requesters + memory).
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        bus_err;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter (fetch/data) onto one single-port memory with timeout
//
// Purpose: grants the shared memory to either the instruction-fetch or the data
// requester, one transaction at a time. Data wins ties unless fetch has been
// passed over STARVE_LIMIT times in a row. A transaction that sees no mem_ready
// for TIMEOUT busy cycles is completed with zero data and a bus_err pulse.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory port, bus_err, busy)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t         state_q;
  logic [SW-1:0]  starve_cnt_q;
  logic [TW-1:0]  timer_q;
  logic [31:0]    mem_addr_q;
  logic [31:0]    mem_wdata_q;
  logic           mem_we_q;

  logic in_i;
  logic in_d;
  logic in_busy;
  logic timeout;
  logic done;
  logic starved;
  logic grant_i;
  logic grant_d;

  always_comb begin
    in_i    = (state_q == BUSY_I);
    in_d    = (state_q == BUSY_D);
    in_busy = in_i | in_d;
    // A real mem_ready in the last allowed cycle wins over the timeout.
    timeout = in_busy & ~bus.mem_ready & (timer_q == TW'(TIMEOUT - 1));
    done    = in_busy & (bus.mem_ready | timeout);
    starved = (starve_cnt_q == SW'(STARVE_LIMIT));
    grant_i = (state_q == IDLE) & bus.i_req & (~bus.d_req | starved);
    grant_d = (state_q == IDLE) & bus.d_req & ~grant_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      timer_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q      <= BUSY_I;
            mem_addr_q   <= bus.i_addr;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
            timer_q      <= '0;
          end else if (grant_d) begin
            state_q     <= BUSY_D;
            mem_addr_q  <= bus.d_addr;
            mem_we_q    <= bus.d_we;
            mem_wdata_q <= bus.d_wdata;
            timer_q     <= '0;
            // Only grants that make a waiting fetch wait count toward starvation.
            if (bus.i_req && !starved) starve_cnt_q <= starve_cnt_q + SW'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) state_q <= IDLE;
          else      timer_q <= timer_q + TW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = in_busy;
  assign bus.busy      = in_busy;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_err   = timeout;

  assign bus.i_ready = in_i & done;
  assign bus.d_ready = in_d & done;
  assign bus.i_rdata = timeout ? 32'h0 : bus.mem_rdata;
  assign bus.d_rdata = (timeout | mem_we_q) ? 32'h0 : bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with directed cases and random traffic
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic clk;
  logic reset;
  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference view of the arbiter: one transaction in flight at most.
  bit          m_busy   = 0;
  bit          m_fetch  = 0;
  logic [31:0] m_addr   = '0;
  bit          m_we     = 0;
  logic [31:0] m_wdata  = '0;
  int          m_age    = 0;   // busy cycles already spent by the current transaction
  int          m_streak = 0;   // data wins in a row while a fetch was waiting
  bit          auto_drop = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    bit tmo;
    bit fin;
    bit was_fetch;
    bit take_fetch;
    #1;
    tmo = m_busy && !bus.mem_ready && (m_age == TIMEOUT - 1);
    fin = m_busy && (bus.mem_ready || tmo);
    was_fetch = m_fetch;
    check_eq("busy", 32'(bus.busy), 32'(m_busy));
    check_eq("mem_req", 32'(bus.mem_req), 32'(m_busy));
    if (m_busy) begin
      check_eq("mem_addr", bus.mem_addr, m_addr);
      check_eq("mem_we", 32'(bus.mem_we), 32'(m_we));
      check_eq("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check_eq("i_ready", 32'(bus.i_ready), 32'(fin && m_fetch));
    check_eq("d_ready", 32'(bus.d_ready), 32'(fin && !m_fetch));
    check_eq("bus_err", 32'(bus.bus_err), 32'(tmo));
    if (fin && m_fetch)
      check_eq("i_rdata", bus.i_rdata, tmo ? 32'h0 : bus.mem_rdata);
    if (fin && !m_fetch)
      check_eq("d_rdata", bus.d_rdata, (tmo || m_we) ? 32'h0 : bus.mem_rdata);

    if (m_busy) begin
      if (fin) m_busy = 0;
      else     m_age++;
    end else if (bus.i_req || bus.d_req) begin
      take_fetch = bus.i_req && (!bus.d_req || m_streak == STARVE_LIMIT);
      if (take_fetch) begin
        m_fetch = 1; m_addr = bus.i_addr; m_we = 0; m_wdata = '0;
        m_streak = 0;
      end else begin
        m_fetch = 0; m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
        if (bus.i_req && m_streak < STARVE_LIMIT) m_streak++;
      end
      m_busy = 1;
      m_age  = 0;
    end

    @(posedge clk); #1;
    if (fin && auto_drop) begin
      if (was_fetch) bus.i_req = 1'b0;
      else           bus.d_req = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_bus_err", 32'(bus.bus_err), 32'h0);
    reset = 1'b0;

    // Single fetch, memory ready one cycle after mem_req
    bus.i_req = 1; bus.i_addr = 32'h0040_0004;
    step();
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("f_mem_addr", bus.mem_addr, 32'h0040_0004);
    check_eq("f_mem_we", 32'(bus.mem_we), 32'h0);
    check_eq("f_i_ready", 32'(bus.i_ready), 32'h1);
    check_eq("f_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
    step();
    bus.mem_ready = 0;
    step();

    // Simultaneous requests: data write first, then fetch
    bus.i_req = 1; bus.i_addr = 32'h0040_0008;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ready = 1; bus.mem_rdata = 32'h1234_5678;
    #1;
    check_eq("t_mem_addr", bus.mem_addr, 32'h1001_0000);
    check_eq("t_mem_we", 32'(bus.mem_we), 32'h1);
    check_eq("t_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check_eq("t_d_ready", 32'(bus.d_ready), 32'h1);
    check_eq("t_d_rdata", bus.d_rdata, 32'h0);
    step();
    bus.mem_ready = 0;
    step();
    #1;
    check_eq("t2_mem_addr", bus.mem_addr, 32'h0040_0008);
    check_eq("t2_mem_we", 32'(bus.mem_we), 32'h0);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;

    // Continuous contention: D,D,D,D,I repeating
    auto_drop = 0;
    bus.i_req = 1; bus.i_addr = 32'h0000_1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_2000;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        #1;
        check_eq($sformatf("starve_r%0d_g%0d", r, k), bus.mem_addr,
                 (k == 4) ? 32'h0000_1000 : 32'h0000_2000);
        bus.mem_ready = 1;
        step();
        bus.mem_ready = 0;
      end
    end
    auto_drop = 1;
    bus.i_req = 0; bus.d_req = 0;
    step();

    // Timeout on a data read
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_3000;
    bus.mem_rdata = 32'hFFFF_0000;
    step();
    for (int a = 0; a < TIMEOUT - 1; a++) begin
      #1;
      check_eq("to_no_ready", 32'(bus.d_ready), 32'h0);
      step();
    end
    #1;
    check_eq("to_d_ready", 32'(bus.d_ready), 32'h1);
    check_eq("to_d_rdata", bus.d_rdata, 32'h0);
    check_eq("to_bus_err", 32'(bus.bus_err), 32'h1);
    step();
    check_eq("to_busy_after", 32'(bus.busy), 32'h0);
    check_eq("to_err_after", 32'(bus.bus_err), 32'h0);

    // mem_ready coinciding with the timeout cycle is a normal completion
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_3004;
    step();
    for (int a = 0; a < TIMEOUT - 1; a++) step();
    bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    check_eq("co_bus_err", 32'(bus.bus_err), 32'h0);
    check_eq("co_d_rdata", bus.d_rdata, 32'h0BAD_F00D);
    step();
    bus.mem_ready = 0;

    // Reset in the middle of a data transaction
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_4000; bus.d_wdata = 32'h5555_AAAA;
    step();
    step();
    reset = 1;
    @(posedge clk); #1;
    bus.mem_ready = 1;
    #1;
    check_eq("rs_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("rs_busy", 32'(bus.busy), 32'h0);
    check_eq("rs_d_ready", 32'(bus.d_ready), 32'h0);
    check_eq("rs_bus_err", 32'(bus.bus_err), 32'h0);
    @(posedge clk); #1;
    check_eq("rs_hold_busy", 32'(bus.busy), 32'h0);
    m_busy = 0; m_streak = 0; m_age = 0;
    reset = 0; bus.mem_ready = 0;
    step();
    #1;
    check_eq("rs_regrant_addr", bus.mem_addr, 32'h0000_4000);
    check_eq("rs_regrant_busy", 32'(bus.busy), 32'h1);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;

    // mem_ready while idle with no request
    bus.mem_ready = 1;
    #1;
    check_eq("idle_i_ready", 32'(bus.i_ready), 32'h0);
    check_eq("idle_d_ready", 32'(bus.d_ready), 32'h0);
    check_eq("idle_bus_err", 32'(bus.bus_err), 32'h0);
    step();
    bus.mem_ready = 0;
    step();
    check_eq("idle_busy", 32'(bus.busy), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!bus.i_req && ($urandom % 4 == 0)) begin
        bus.i_req = 1; bus.i_addr = $urandom;
      end
      if (!bus.d_req && ($urandom % 3 == 0)) begin
        bus.d_req = 1; bus.d_we = $urandom % 2; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      // The granted requester may let go early; its transaction must still finish.
      if (m_busy && ($urandom % 8 == 0)) begin
        if (m_fetch) bus.i_req = 0;
        else         bus.d_req = 0;
      end
      bus.mem_ready = m_busy ? ($urandom % 6 == 0) : ($urandom % 3 == 0);
      bus.mem_rdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
